// File: rtl/sram_stream_reader.sv
// sram_stream_reader
// Read-side master for the 8K x 16 SRAM. A start command sweeps a contiguous
// address range, one word per clock, into a 2-entry output buffer that feeds a
// valid/ready stream with a last marker. A one-cycle done pulse closes each
// request.
// Build option: define SRAM_RD_WRAP_EN to let a request wrap from the top word
// back to address 0. Without it, requests are clipped at the top of memory.
module sram_stream_reader #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 14
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ReadAddress,
  input  logic [DATA_W-1:0] ReadBus,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready
);

`ifndef SRAM_RD_WRAP_EN
  // Number of words in the SRAM and its highest address.
  localparam logic [LEN_W-1:0]  DEPTH    = LEN_W'(1'b1) << ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Address following a captured word: wraps modulo 2^ADDR_W, or saturates
  // at the top word when wrapping is not built in.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
`ifdef SRAM_RD_WRAP_EN
    return a + ADDR_W'(1'b1);
`else
    if (a == ADDR_MAX) begin
      return a;
    end else begin
      return a + ADDR_W'(1'b1);
    end
`endif
  endfunction

  state_t              state_r;
  state_t              state_s;
  logic                busy_r;
  logic                done_r;
  logic                busy_s;
  logic                done_s;

  logic [ADDR_W-1:0]   addr_r;
  logic [LEN_W-1:0]    remaining_r;
  logic [LEN_W-1:0]    load_len_s;
  logic                load_s;

  logic [DATA_W-1:0]   head_data_r;
  logic                head_last_r;
  logic [DATA_W-1:0]   tail_data_r;
  logic                tail_last_r;
  logic [1:0]          count_r;
  logic [1:0]          count_s;
  logic                valid_r;

  logic                pop_s;
  logic                capture_s;
  logic                cap_last_s;
  logic                last_pop_s;

  // Handshake, capture and end-of-request qualifiers.
  always_comb begin
    pop_s      = valid_r & out_ready;
    cap_last_s = (remaining_r == LEN_W'(1'b1));
    load_s     = (state_r == ST_IDLE) && start && (length != {LEN_W{1'b0}});
    if ((state_r == ST_FETCH) && (remaining_r != {LEN_W{1'b0}}) &&
        ((count_r != 2'd2) || pop_s)) begin
      capture_s = 1'b1;
    end else begin
      capture_s = 1'b0;
    end
    last_pop_s = pop_s & head_last_r;
  end

  // Word count loaded at start: full length when wrapping, otherwise clipped
  // so the sweep ends on the top word.
`ifdef SRAM_RD_WRAP_EN
  always_comb begin
    load_len_s = length;
  end
`else
  logic [LEN_W-1:0] room_s;
  always_comb begin
    room_s = DEPTH - LEN_W'(start_addr);
    if (length > room_s) begin
      load_len_s = room_s;
    end else begin
      load_len_s = length;
    end
  end
`endif

  // State register together with the registered status outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (length == {LEN_W{1'b0}}) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_FETCH;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (capture_s && cap_last_s) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (last_pop_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Status outputs decoded from the upcoming state so they register in step.
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_s)
      ST_IDLE: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
      ST_FETCH, ST_DRAIN: begin
        busy_s = 1'b1;
        done_s = 1'b0;
      end
      ST_DONE: begin
        busy_s = 1'b1;
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // Read address and remaining word count: loaded on start, stepped on capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_r      <= {ADDR_W{1'b0}};
      remaining_r <= {LEN_W{1'b0}};
    end else if (load_s) begin
      addr_r      <= start_addr;
      remaining_r <= load_len_s;
    end else if (capture_s) begin
      addr_r      <= next_addr(addr_r);
      remaining_r <= remaining_r - LEN_W'(1'b1);
    end else begin
      addr_r      <= addr_r;
      remaining_r <= remaining_r;
    end
  end

  // Buffer occupancy after this cycle's push and pop.
  always_comb begin
    count_s = count_r;
    if (capture_s && !pop_s) begin
      count_s = count_r + 2'd1;
    end else if (!capture_s && pop_s) begin
      count_s = count_r - 2'd1;
    end else begin
      count_s = count_r;
    end
  end

  // Two-entry buffer kept as head/tail registers so the head drives the
  // stream outputs straight from flops and holds while stalled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_data_r <= {DATA_W{1'b0}};
      head_last_r <= 1'b0;
      tail_data_r <= {DATA_W{1'b0}};
      tail_last_r <= 1'b0;
      count_r     <= 2'd0;
      valid_r     <= 1'b0;
    end else begin
      count_r <= count_s;
      valid_r <= (count_s != 2'd0);
      case ({capture_s, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            head_data_r <= ReadBus;
            head_last_r <= cap_last_s;
          end else begin
            tail_data_r <= ReadBus;
            tail_last_r <= cap_last_s;
          end
        end
        2'b01: begin
          if (count_r == 2'd2) begin
            head_data_r <= tail_data_r;
            head_last_r <= tail_last_r;
          end else begin
            head_last_r <= 1'b0;
          end
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            head_data_r <= ReadBus;
            head_last_r <= cap_last_s;
          end else begin
            head_data_r <= tail_data_r;
            head_last_r <= tail_last_r;
            tail_data_r <= ReadBus;
            tail_last_r <= cap_last_s;
          end
        end
        default: begin
          head_data_r <= head_data_r;
          head_last_r <= head_last_r;
        end
      endcase
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign ReadAddress = addr_r;
  assign out_valid   = valid_r;
  assign out_data    = head_data_r;
  assign out_last    = head_last_r;

endmodule

// File: tb/tb_sram_stream_reader.sv
// Self-checking bench for sram_stream_reader: table of directed requests,
// hand-written stall / busy-start / reset sequences and randomized requests,
// all checked against a word-level model of the request.
module tb_sram_stream_reader;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 14;
  localparam int DEPTH  = 8192;

  logic              clock = 1'b0;
  logic              reset_n = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [LEN_W-1:0]  length = '0;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] ReadAddress;
  logic [DATA_W-1:0] ReadBus;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready = 1'b0;

  logic [DATA_W-1:0] sram [DEPTH];
  assign ReadBus = sram[ReadAddress];

  always #5 clock = ~clock;

  sram_stream_reader dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .start_addr  (start_addr),
    .length      (length),
    .busy        (busy),
    .done        (done),
    .ReadAddress (ReadAddress),
    .ReadBus     (ReadBus),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_ready   (out_ready)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
  } word_t;

  typedef struct {
    int addr;
    int len;
    int mode;
    int exp_done;
  } vec_t;

  int    vec_cnt = 0;
  int    miss_cnt = 0;
  word_t got_q[$];
  int    tick_no = 0;
  int    done_tick = -1;
  int    done_count = 0;
  logic  prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  logic  prev_last = 1'b0;
  vec_t  vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Number of words a request delivers.
  function automatic int model_len(input int a, input int l);
`ifdef SRAM_RD_WRAP_EN
    return l;
`else
    return (l > DEPTH - a) ? (DEPTH - a) : l;
`endif
  endfunction

  function automatic logic [DATA_W-1:0] model_word(input int a, input int i);
    return 16'(32'hA000 + ((a + i) % DEPTH));
  endfunction

  // mode 0: ready always high; 1: pattern 1,0,0 repeating; 2: random.
  function automatic logic ready_for(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ((k % 3) == 0);
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock: sample on the falling edge, then step past the rising edge.
  task automatic tick();
    @(negedge clock);
    tick_no++;
    if (prev_stall) begin
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_data", {16'd0, out_data}, {16'd0, prev_data});
      check("stall_last", {31'd0, out_last}, {31'd0, prev_last});
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_last  = out_last;
    if (out_valid && out_ready) got_q.push_back('{out_data, out_last});
    if (done) begin
      done_count++;
      if (done_tick < 0) done_tick = tick_no;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input int a, input int l, input int mode);
    got_q.delete();
    prev_stall = 1'b0;
    start      = 1'b1;
    start_addr = a[ADDR_W-1:0];
    length     = l[LEN_W-1:0];
    out_ready  = ready_for(mode, 0);
    tick();
    start      = 1'b0;
    tick_no    = 0;
    done_tick  = -1;
    done_count = 0;
  endtask

  task automatic finish_req(input string tag, input int a, input int l, input int mode, input int exp_done);
    int n;
    int budget;
    n = model_len(a, l);
    budget = 4 * n + 20;
    for (int i = 0; i < budget && done_tick < 0; i++) begin
      out_ready = ready_for(mode, tick_no);
      tick();
    end
    check({tag, " done_seen"}, {31'd0, (done_tick >= 0)}, 32'd1);
    if (exp_done > 0) check({tag, " done_cycle"}, done_tick, exp_done);
    check({tag, " busy_after"}, {31'd0, busy}, 32'd0);
    check({tag, " done_after"}, {31'd0, done}, 32'd0);
    out_ready = 1'b1;
    tick();
    check({tag, " done_pulses"}, done_count, 32'd1);
    check({tag, " word_count"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      check($sformatf("%s data[%0d]", tag, i), {16'd0, got_q[i].data}, {16'd0, model_word(a, i)});
      check($sformatf("%s last[%0d]", tag, i), {31'd0, got_q[i].last}, {31'd0, (i == n - 1)});
    end
  endtask

  task automatic run_req(input string tag, input int a, input int l, input int mode, input int exp_done);
    logic [ADDR_W-1:0] addr_before;
    addr_before = ReadAddress;
    issue(a, l, mode);
    check({tag, " busy_start"}, {31'd0, busy}, 32'd1);
    if (model_len(a, l) != 0)
      check({tag, " addr_start"}, {19'd0, ReadAddress}, a);
    else
      check({tag, " addr_kept"}, {19'd0, ReadAddress}, {19'd0, addr_before});
    finish_req(tag, a, l, mode, exp_done);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " busy"}, {31'd0, busy}, 32'd0);
    check({tag, " done"}, {31'd0, done}, 32'd0);
    check({tag, " addr"}, {19'd0, ReadAddress}, 32'd0);
    check({tag, " valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, " last"}, {31'd0, out_last}, 32'd0);
    check({tag, " data"}, {16'd0, out_data}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) sram[i] = 16'(32'hA000 + i);

    vecs[0] = '{32'h0010, 4, 0, 6};
    vecs[1] = '{32'h0100, 0, 0, 1};
    vecs[2] = '{32'h0020, 6, 1, 0};
`ifdef SRAM_RD_WRAP_EN
    vecs[3] = '{8190, 4, 0, 6};
`else
    vecs[3] = '{8190, 4, 0, 4};
`endif
    vecs[4] = '{8191, 1, 0, 3};
    vecs[5] = '{0, 9, 2, 0};

    #1 reset_n = 1'b0;
    #1 check_reset_values("reset");
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    tick();

    for (int v = 0; v < 6; v++)
      run_req($sformatf("vec%0d", v), vecs[v].addr, vecs[v].len, vecs[v].mode, vecs[v].exp_done);

    // Backpressure from the first word: address stops two past the start.
    issue(32'h40, 6, 0);
    out_ready = 1'b0;
    check("hold addr0", {19'd0, ReadAddress}, 32'h40);
    tick();
    check("hold addr1", {19'd0, ReadAddress}, 32'h41);
    tick();
    check("hold addr2", {19'd0, ReadAddress}, 32'h42);
    check("hold head", {16'd0, out_data}, 32'hA040);
    tick();
    check("hold addr3", {19'd0, ReadAddress}, 32'h42);
    tick();
    check("hold addr4", {19'd0, ReadAddress}, 32'h42);
    finish_req("hold", 32'h40, 6, 0, 0);

    // A start while busy must not disturb the running request.
    issue(32'h80, 5, 0);
    tick();
    start      = 1'b1;
    start_addr = 13'h0300;
    length     = 14'd3;
    tick();
    start = 1'b0;
    check("busy_start addr", {19'd0, ReadAddress}, 32'h82);
    finish_req("busy_start", 32'h80, 5, 0, 7);

    // Asynchronous reset in the middle of a request.
    issue(32'h200, 8, 0);
    tick();
    tick();
    #2 reset_n = 1'b0;
    #1 check_reset_values("midreset");
    tick();
    reset_n = 1'b1;
    got_q.delete();
    done_count = 0;
    prev_stall = 1'b0;
    repeat (6) tick();
    check("midreset done_pulses", done_count, 32'd0);
    check("midreset words", got_q.size(), 32'd0);
    check("midreset busy", {31'd0, busy}, 32'd0);

    for (int r = 0; r < 20; r++) begin
      int a;
      int l;
      int m;
      int n;
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8150, 8191)) : int'($urandom_range(0, 8191));
      l = $urandom_range(0, 40);
      m = $urandom_range(0, 2);
      n = model_len(a, l);
      run_req($sformatf("rand%0d", r), a, l, m, (m == 0) ? ((n == 0) ? 1 : n + 2) : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
